uart_rx_inbuf: RTL

- Serial receiver feeding the input-buffer FIFO; sits directly upstream of it.
- Deserialises 8N1 UART frames from the rx pin and issues one push per good byte.
- Obeys FIFO push rules: never pushes while full, never pushes on two consecutive cycles, holds data stable the cycle after a push.
- Drops bytes on overrun or framing error and reports each with a one-cycle pulse.

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_rx_inbuf_sync_ff.sv | 16 +
 rtl/uart_rx_inbuf.sv | 92 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding and frame width
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    localparam int DATA_BITS = 8;
endpackage

// File: rtl/uart_rx_inbuf_sync_ff.sv
// sync_ff: STAGES-deep synchroniser, resets to 1 (line idle)
//   clk, rst (async active-low), i_d async input, o_q synchronised output
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_sync <= '1;
        else r_sync <= {r_sync[STAGES-2:0], i_d};
    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/uart_rx_inbuf.sv
// uart_rx_inbuf: 8N1 UART receiver pushing good bytes into the input FIFO
//   clk, rst (async active-low), rx serial in, full FIFO flag
//   push_back one-cycle push, data_out byte, overrun/frame_err one-cycle drop pulses
module uart_rx_inbuf
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       full,
    output logic       push_back,
    output logic [7:0] data_out,
    output logic       overrun,
    output logic       frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    logic                 w_rx_s;
    logic                 w_tick;
    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [2:0]           r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_armed;
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );
    assign w_tick = r_cnt == '0;
    // r_armed: a start edge only counts after the line has been seen high,
    // so a held break yields a single frame_err rather than a stream of them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_armed   <= 1'b0;
            push_back <= 1'b0;
            data_out  <= 8'h00;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_back <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                IDLE:
                    if (r_armed && !w_rx_s) begin
                        r_cnt   <= HALF;
                        r_armed <= 1'b0;
                        r_state <= START;
                    end else r_armed <= w_rx_s;
                START:
                    if (!w_tick) r_cnt <= r_cnt - 1'b1;
                    else if (w_rx_s) begin
                        r_armed <= 1'b1;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= LAST;
                        r_idx   <= '0;
                        r_state <= DATA;
                    end
                DATA:
                    if (!w_tick) r_cnt <= r_cnt - 1'b1;
                    else begin
                        r_shift[r_idx] <= w_rx_s;
                        r_cnt          <= LAST;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'(DATA_BITS - 1)) r_state <= STOP;
                    end
                STOP:
                    if (!w_tick) r_cnt <= r_cnt - 1'b1;
                    else begin
                        r_state   <= IDLE;
                        r_armed   <= w_rx_s;
                        frame_err <= !w_rx_s;
                        overrun   <= w_rx_s && full;
                        push_back <= w_rx_s && !full;
                        if (w_rx_s && !full) data_out <= r_shift;
                    end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
